// File: rtl/fpu_exc_if.sv
// Handshake and data bundle between an FPU datapath and the exception resolver.
// The master side produces operands and consumes results; the slave is the resolver.
interface fpu_exc_if;
    logic        in_valid;
    logic        in_ready;
    logic        op_sel;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] raw_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        exc_flag;

    modport master (
        output in_valid, op_sel, op1, op2, raw_result, out_ready,
        input  in_ready, out_valid, result, exc_flag
    );

    modport slave (
        input  in_valid, op_sel, op1, op2, raw_result, out_ready,
        output in_ready, out_valid, result, exc_flag
    );
endinterface

// File: rtl/fpu_exc_resolve.sv
// Two-stage IEEE-754 single special-case resolver: S1 captures the bundle and operand
// classes, S2 holds the resolved result. Events feed sticky status flags.
module fpu_exc_resolve (
    input  logic       clk,
    input  logic       rst_n,
    fpu_exc_if.slave   bus,
    input  logic       clr_sticky,
    output logic       sticky_invalid,
    output logic       sticky_special,
    output logic       sticky_overflow
);

    // {nan, inf, zero}
    function automatic logic [2:0] classify(input logic [31:0] x);
        logic exp_ones;
        logic mant_zero;
        exp_ones  = (x[30:23] == 8'hFF);
        mant_zero = (x[22:0] == 23'h0);
        return {exp_ones & ~mant_zero, exp_ones & mant_zero, (x[30:0] == 31'h0)};
    endfunction

    logic        s1_valid;
    logic        s1_op_sel;
    logic        s1_sign1, s1_sign2;
    logic [2:0]  s1_cls1, s1_cls2;
    logic [31:0] s1_raw;

    logic        out_valid_q;
    logic [31:0] result_q;
    logic        exc_q;

    logic        s2_adv, s1_adv, load_s2;
    logic        nan1, inf1, zero1, nan2, inf2, zero2;
    logic [31:0] res_c;
    logic        exc_c, ev_inv, ev_spc, ev_ovf;

    assign s2_adv       = ~out_valid_q | bus.out_ready;
    assign s1_adv       = ~s1_valid | s2_adv;
    assign load_s2      = s2_adv & s1_valid;
    assign bus.in_ready = s1_adv;

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.exc_flag  = exc_q;

    assign {nan1, inf1, zero1} = s1_cls1;
    assign {nan2, inf2, zero2} = s1_cls2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op_sel <= 1'b0;
            s1_sign1  <= 1'b0;
            s1_sign2  <= 1'b0;
            s1_cls1   <= 3'b0;
            s1_cls2   <= 3'b0;
            s1_raw    <= 32'h0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_op_sel <= bus.op_sel;
                s1_sign1  <= bus.op1[31];
                s1_sign2  <= bus.op2[31];
                s1_cls1   <= classify(bus.op1);
                s1_cls2   <= classify(bus.op2);
                s1_raw    <= bus.raw_result;
            end
        end
    end

    // Rules are checked in priority order; the first match wins.
    always_comb begin
        res_c  = s1_raw;
        exc_c  = 1'b0;
        ev_inv = 1'b0;
        ev_spc = 1'b0;
        ev_ovf = 1'b0;
        if (nan1 | nan2) begin
            res_c  = 32'hFFFF_FFFF;
            exc_c  = 1'b1;
            ev_inv = 1'b1;
        end else if (!s1_op_sel && inf1 && inf2 && (s1_sign1 != s1_sign2)) begin
            res_c  = 32'hFFFF_FFFF;
            exc_c  = 1'b1;
            ev_inv = 1'b1;
        end else if (s1_op_sel && ((zero1 && inf2) || (inf1 && zero2))) begin
            res_c  = 32'hFFFF_FFFF;
            exc_c  = 1'b1;
            ev_inv = 1'b1;
        end else if (!s1_op_sel && (inf1 || inf2)) begin
            res_c  = {(inf1 ? s1_sign1 : s1_sign2), 8'hFF, 23'h0};
            exc_c  = 1'b1;
            ev_spc = 1'b1;
        end else if (s1_op_sel && (inf1 || inf2)) begin
            res_c  = {s1_sign1 ^ s1_sign2, 8'hFF, 23'h0};
            exc_c  = 1'b1;
            ev_spc = 1'b1;
        end else begin
            ev_ovf = (s1_raw[30:23] == 8'hFF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= 32'h0;
            exc_q       <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                result_q <= res_c;
                exc_q    <= exc_c;
            end
        end
    end

    // An event arriving with clr_sticky wins, so no event is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_invalid  <= 1'b0;
            sticky_special  <= 1'b0;
            sticky_overflow <= 1'b0;
        end else begin
            sticky_invalid  <= (sticky_invalid  & ~clr_sticky) | (load_s2 & ev_inv);
            sticky_special  <= (sticky_special  & ~clr_sticky) | (load_s2 & ev_spc);
            sticky_overflow <= (sticky_overflow & ~clr_sticky) | (load_s2 & ev_ovf);
        end
    end

endmodule

// File: tb/tb_fpu_exc_resolve.sv
// Directed bench for fpu_exc_resolve: special-case rules, latency, backpressure,
// sticky clear precedence and mid-flight reset.
module tb_fpu_exc_resolve;

    logic clk;
    logic rst_n;
    logic clr_sticky;
    logic sticky_invalid, sticky_special, sticky_overflow;

    fpu_exc_if bus();

    fpu_exc_resolve dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .clr_sticky      (clr_sticky),
        .sticky_invalid  (sticky_invalid),
        .sticky_special  (sticky_special),
        .sticky_overflow (sticky_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive a bundle at a negedge and return at the negedge after it was accepted.
    task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] raw);
        int n;
        bus.in_valid   = 1'b1;
        bus.op_sel     = op;
        bus.op1        = a;
        bus.op2        = b;
        bus.raw_result = raw;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] res, input logic exc);
        int n;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_result"}, bus.result, res);
        chk({tag, "_exc"}, 32'(bus.exc_flag), 32'(exc));
    endtask

    task automatic run_vec(input string tag, input logic op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] raw,
                           input logic [31:0] res, input logic exc);
        send(op, a, b, raw);
        bus.in_valid = 1'b0;
        expect_out(tag, res, exc);
    endtask

    task automatic pulse_clear();
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
    endtask

    logic        bp_op  [4];
    logic [31:0] bp_a   [4];
    logic [31:0] bp_b   [4];
    logic [31:0] bp_raw [4];
    logic [31:0] bp_res [4];
    logic        bp_exc [4];

    task automatic drive_bp(input int i);
        if (i < 4) begin
            bus.in_valid   = 1'b1;
            bus.op_sel     = bp_op[i];
            bus.op1        = bp_a[i];
            bus.op2        = bp_b[i];
            bus.raw_result = bp_raw[i];
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int in_idx, out_idx, accepts, stale;
        logic acc;

        bp_op[0] = 1'b0; bp_a[0] = 32'h3F80_0000; bp_b[0] = 32'h3F80_0000;
        bp_raw[0] = 32'h4000_0000; bp_res[0] = 32'h4000_0000; bp_exc[0] = 1'b0;
        bp_op[1] = 1'b1; bp_a[1] = 32'hBF80_0000; bp_b[1] = 32'h7F80_0000;
        bp_raw[1] = 32'h1234_5678; bp_res[1] = 32'hFF80_0000; bp_exc[1] = 1'b1;
        bp_op[2] = 1'b0; bp_a[2] = 32'h4000_0000; bp_b[2] = 32'h4000_0000;
        bp_raw[2] = 32'h4080_0000; bp_res[2] = 32'h4080_0000; bp_exc[2] = 1'b0;
        bp_op[3] = 1'b0; bp_a[3] = 32'h3F80_0000; bp_b[3] = 32'h4000_0000;
        bp_raw[3] = 32'h4040_0000; bp_res[3] = 32'h4040_0000; bp_exc[3] = 1'b0;

        rst_n          = 1'b0;
        clr_sticky     = 1'b0;
        bus.in_valid   = 1'b0;
        bus.op_sel     = 1'b0;
        bus.op1        = 32'h0;
        bus.op2        = 32'h0;
        bus.raw_result = 32'h0;
        bus.out_ready  = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_exc", 32'(bus.exc_flag), 32'd0);
        chk("rst_stickies", 32'({sticky_invalid, sticky_special, sticky_overflow}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Inf + -Inf with explicit latency checks.
        send(1'b0, 32'h7F80_0000, 32'hFF80_0000, 32'h0);
        bus.in_valid = 1'b0;
        chk("lat_not_yet", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("infsub_result", bus.result, 32'hFFFF_FFFF);
        chk("infsub_exc", 32'(bus.exc_flag), 32'd1);
        chk("infsub_sticky_inv", 32'(sticky_invalid), 32'd1);
        chk("infsub_sticky_spc", 32'(sticky_special), 32'd0);
        pulse_clear();
        chk("clear_inv", 32'(sticky_invalid), 32'd0);

        run_vec("mul_zero_inf", 1'b1, 32'h0000_0000, 32'h7F80_0000, 32'h0, 32'hFFFF_FFFF, 1'b1);
        chk("mul_zero_inf_sticky", 32'(sticky_invalid), 32'd1);
        run_vec("mul_neg_inf", 1'b1, 32'hBF80_0000, 32'h7F80_0000, 32'h0, 32'hFF80_0000, 1'b1);
        chk("mul_neg_inf_sticky", 32'(sticky_special), 32'd1);
        run_vec("add_finite", 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1'b0);
        chk("add_finite_no_ovf", 32'(sticky_overflow), 32'd0);
        run_vec("add_ovf", 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000, 1'b0);
        chk("add_ovf_sticky", 32'(sticky_overflow), 32'd1);
        run_vec("nan_prio", 1'b0, 32'h7FC0_0000, 32'h7F80_0000, 32'h0, 32'hFFFF_FFFF, 1'b1);
        run_vec("add_inf_op2", 1'b0, 32'h3F80_0000, 32'hFF80_0000, 32'h0, 32'hFF80_0000, 1'b1);
        run_vec("add_inf_same", 1'b0, 32'h7F80_0000, 32'h7F80_0000, 32'h0, 32'h7F80_0000, 1'b1);
        run_vec("mul_finite_zero", 1'b1, 32'h3F80_0000, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0);
        run_vec("mul_negzero_inf", 1'b1, 32'h8000_0000, 32'hFF80_0000, 32'h0, 32'hFFFF_FFFF, 1'b1);

        // Backpressure: four back-to-back inputs, consumer stalled for five cycles.
        pulse_clear();
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        in_idx  = 0;
        out_idx = 0;
        accepts = 0;
        drive_bp(0);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (cyc >= 2 && cyc <= 6) begin
                chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
                chk("bp_hold_result", bus.result, bp_res[0]);
                chk("bp_hold_exc", 32'(bus.exc_flag), 32'(bp_exc[0]));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (out_idx < 4) begin
                    chk("bp_order_result", bus.result, bp_res[out_idx]);
                    chk("bp_order_exc", 32'(bus.exc_flag), 32'(bp_exc[out_idx]));
                end else begin
                    chk("bp_extra_output", 32'(out_idx), 32'd3);
                end
                out_idx++;
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                accepts++;
                in_idx++;
                drive_bp(in_idx);
            end
            if (cyc == 6) begin
                chk("bp_accepts_while_stalled", 32'(accepts), 32'd2);
                bus.out_ready = 1'b1;
            end
        end
        chk("bp_all_in", 32'(in_idx), 32'd4);
        chk("bp_all_out", 32'(out_idx), 32'd4);
        chk("bp_sticky_special", 32'(sticky_special), 32'd1);

        // Clear coinciding with an invalid event: the event must win.
        @(negedge clk);
        pulse_clear();
        chk("pre_clr_inv", 32'(sticky_invalid), 32'd0);
        send(1'b0, 32'h7FC0_0001, 32'h3F80_0000, 32'h0);
        bus.in_valid = 1'b0;
        clr_sticky   = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("clr_event_valid", 32'(bus.out_valid), 32'd1);
        chk("clr_event_result", bus.result, 32'hFFFF_FFFF);
        chk("clr_event_sticky", 32'(sticky_invalid), 32'd1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("clr_alone_sticky", 32'(sticky_invalid), 32'd0);

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        send(1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'hAAAA_0000);
        send(1'b1, 32'hBF80_0000, 32'h7F80_0000, 32'h0);
        bus.in_valid = 1'b0;
        chk("full_before_rst", 32'(bus.out_valid), 32'd1);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_result", bus.result, 32'h0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("async_rst_sticky", 32'(sticky_special), 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        chk("no_stale_after_rst", 32'(stale), 32'd0);
        run_vec("post_rst", 1'b0, 32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 32'h4040_0000, 1'b0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
